// File: rtl/hdlc_tx_framer_if.sv
// Register-side bus of the HDLC transmit framer.
//   master (host): drives wr_data, wr_en, start, abort;
//                  observes full, frame_size, busy, done, aborted.
//   slave (framer): the mirror image.
interface hdlc_tx_framer_if #(
  parameter int unsigned ADDR_W = 7
);
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            start;
  logic            abort;
  logic            full;
  logic [ADDR_W:0] frame_size;
  logic            busy;
  logic            done;
  logic            aborted;

  modport master (
    output wr_data, wr_en, start, abort,
    input  full, frame_size, busy, done, aborted
  );

  modport slave (
    input  wr_data, wr_en, start, abort,
    output full, frame_size, busy, done, aborted
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: buffers one frame of bytes, then sends opening flag, zero-stuffed
// data and FCS, closing flag and an idle gap, one line bit per bit_en_i strobe, LSB first.
// Compile-time option: define HDLC_FCS32_EN for CRC-32 FCS; otherwise CRC-16/X-25.
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   bit_en_i  bit-rate strobe
//   tx_o      registered serial line
//   tx_en_o   high while flag, data, FCS or abort bits are on the line
//   host_io   register-side bus (write, start, abort, status)
module hdlc_tx_framer #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned GAP_BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            bit_en_i,
  output logic            tx_o,
  output logic            tx_en_o,
  hdlc_tx_framer_if.slave host_io
);

`ifdef HDLC_FCS32_EN
  localparam int unsigned     FcsW    = 32;
  localparam logic [FcsW-1:0] FcsPoly = 32'hEDB8_8320;
`else
  localparam int unsigned     FcsW    = 16;
  localparam logic [FcsW-1:0] FcsPoly = 16'h8408;
`endif
  localparam int unsigned GapW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [2:0] {StIdle, StOpen, StData, StFcs, StClose, StGap, StAbort} state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [CntW-1:0] count_q, rd_ptr_q;
  logic [FcsW-1:0] sh_q, crc_q;
  logic [4:0]      bit_cnt_q;
  logic [2:0]      ones_q;
  logic [GapW-1:0] gap_cnt_q;
  logic            abort_pend_q, was_abort_q;
  logic            tx_q, tx_en_q, busy_q, done_q, aborted_q;

  logic            full, wr_ok, start_ok, abort_go, stuff, cur_bit, flag_bit, more_bytes;
  logic [FcsW-1:0] crc_nxt, next_byte;

  always_comb begin
    full       = (count_q == CntW'(DEPTH)) || busy_q;
    wr_ok      = host_io.wr_en && !full;
    // A byte written in the same cycle as Start belongs to the frame.
    start_ok   = host_io.start && (state_q == StIdle) && ((count_q != '0) || wr_ok);
    abort_go   = (state_q inside {StOpen, StData, StFcs}) && (host_io.abort || abort_pend_q);
    stuff      = (ones_q == 3'd5);
    cur_bit    = sh_q[0];
    flag_bit   = (bit_cnt_q[2:0] != 3'd0) && (bit_cnt_q[2:0] != 3'd7);
    crc_nxt    = (crc_q >> 1) ^ ((crc_q[0] ^ cur_bit) ? FcsPoly : '0);
    more_bytes = (rd_ptr_q != count_q);
    // rd_ptr_q is 0 while the opening flag goes out, so this also fetches the first byte.
    next_byte  = {{(FcsW-8){1'b0}}, mem_q[rd_ptr_q[ADDR_W-1:0]]};
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[count_q[ADDR_W-1:0]] <= host_io.wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      sh_q         <= '0;
      crc_q        <= '1;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      gap_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      was_abort_q  <= 1'b0;
      tx_q         <= 1'b1;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (wr_ok) count_q <= count_q + CntW'(1);
      // Abort seen between strobes waits for the next strobe; cleared below when acted on.
      if (host_io.abort && (state_q inside {StOpen, StData, StFcs})) abort_pend_q <= 1'b1;

      if (state_q == StIdle) begin
        if (start_ok) begin
          state_q     <= StOpen;
          busy_q      <= 1'b1;
          bit_cnt_q   <= '0;
          ones_q      <= '0;
          was_abort_q <= 1'b0;
        end
      end else if (bit_en_i) begin
        if (abort_go) begin
          // First abort bit (0) replaces the next scheduled bit; seven 1s follow.
          tx_q         <= 1'b0;
          tx_en_q      <= 1'b1;
          state_q      <= StAbort;
          bit_cnt_q    <= 5'd1;
          abort_pend_q <= 1'b0;
          was_abort_q  <= 1'b1;
        end else begin
          case (state_q)
            StOpen: begin
              tx_q      <= flag_bit;
              tx_en_q   <= 1'b1;
              ones_q    <= '0;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                state_q   <= StData;
                sh_q      <= next_byte;
                rd_ptr_q  <= rd_ptr_q + CntW'(1);
                bit_cnt_q <= '0;
                crc_q     <= '1;
              end
            end
            StData, StFcs: begin
              if (stuff) begin
                tx_q   <= 1'b0;
                ones_q <= '0;
              end else begin
                tx_q      <= cur_bit;
                ones_q    <= cur_bit ? ones_q + 3'd1 : 3'd0;
                sh_q      <= sh_q >> 1;
                bit_cnt_q <= bit_cnt_q + 5'd1;
                if (state_q == StData) begin
                  crc_q <= crc_nxt;
                  if (bit_cnt_q == 5'd7) begin
                    bit_cnt_q <= '0;
                    if (more_bytes) begin
                      sh_q     <= next_byte;
                      rd_ptr_q <= rd_ptr_q + CntW'(1);
                    end else begin
                      state_q <= StFcs;
                      sh_q    <= ~crc_nxt;
                    end
                  end
                end else if (bit_cnt_q == 5'(FcsW - 1)) begin
                  state_q   <= StClose;
                  bit_cnt_q <= '0;
                end
              end
            end
            StClose: begin
              // A run of five 1s at the end of the FCS still needs its stuffed 0.
              if (stuff) begin
                tx_q   <= 1'b0;
                ones_q <= '0;
              end else begin
                tx_q      <= flag_bit;
                ones_q    <= '0;
                bit_cnt_q <= bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd7) begin
                  state_q   <= StGap;
                  bit_cnt_q <= '0;
                  gap_cnt_q <= '0;
                end
              end
            end
            StAbort: begin
              tx_q      <= 1'b1;
              bit_cnt_q <= bit_cnt_q + 5'd1;
              if (bit_cnt_q == 5'd7) begin
                state_q   <= StGap;
                bit_cnt_q <= '0;
                gap_cnt_q <= '0;
              end
            end
            StGap: begin
              tx_q      <= 1'b1;
              tx_en_q   <= 1'b0;
              gap_cnt_q <= gap_cnt_q + GapW'(1);
              if (gap_cnt_q == GapW'(GAP_BITS - 1)) begin
                state_q   <= StIdle;
                busy_q    <= 1'b0;
                count_q   <= '0;
                rd_ptr_q  <= '0;
                done_q    <= !was_abort_q;
                aborted_q <= was_abort_q;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign tx_o               = tx_q;
  assign tx_en_o            = tx_en_q;
  assign host_io.full       = full;
  assign host_io.frame_size = count_q;
  assign host_io.busy       = busy_q;
  assign host_io.done       = done_q;
  assign host_io.aborted    = aborted_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
module tb_hdlc_tx_framer;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned GAP   = 8;
`ifdef HDLC_FCS32_EN
  localparam logic [31:0] POLY = 32'hEDB8_8320;
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
  localparam logic [31:0] KAT  = 32'hCBF4_3926;
  localparam int          FCSW = 32;
`else
  localparam logic [31:0] POLY = 32'h0000_8408;
  localparam logic [31:0] MASK = 32'h0000_FFFF;
  localparam logic [31:0] KAT  = 32'h0000_906E;
  localparam int          FCSW = 16;
`endif

  typedef struct {
    logic tx;
    logic txen;
    bit   last;
    int   kind;  // 1 = done, 2 = aborted
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_en = 1'b0;
  logic tx, tx_en;
  int   mode = 0;  // 0: BitEn=1, 1: random BitEn, 2: BitEn=0

  hdlc_tx_framer_if #(.ADDR_W(AW)) host_if ();

  hdlc_tx_framer #(.DEPTH(DEPTH), .ADDR_W(AW), .GAP_BITS(GAP)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bit_en_i(bit_en),
    .tx_o    (tx),
    .tx_en_o (tx_en),
    .host_io (host_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    case (mode)
      0:       bit_en = 1'b1;
      1:       bit_en = ($urandom_range(0, 2) != 0);
      default: bit_en = 1'b0;
    endcase
  end

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [7:0]  buf_q[$];
  logic        line_q[$];
  int          byte3_pos;
  bit          model_busy = 1'b0;
  int          frame_len;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: line bits (flags + stuffed data/FCS) of the frame held in buf_q.
  task automatic build_line(input bit use_kat);
    logic        content[$];
    logic [31:0] crc;
    logic [7:0]  flag;
    int          ones;
    crc  = MASK;
    flag = 8'h7E;
    line_q.delete();
    byte3_pos = 0;
    foreach (buf_q[i]) begin
      for (int j = 0; j < 8; j++) begin
        logic b;
        b = buf_q[i][j];
        content.push_back(b);
        crc = (crc[0] ^ b) ? ((crc >> 1) ^ POLY) : (crc >> 1);
      end
    end
    crc = use_kat ? KAT : (~crc & MASK);
    for (int j = 0; j < FCSW; j++) content.push_back(crc[j]);
    for (int j = 0; j < 8; j++) line_q.push_back(flag[j]);
    ones = 0;
    foreach (content[i]) begin
      if (i == 16) byte3_pos = line_q.size();
      line_q.push_back(content[i]);
      ones = content[i] ? ones + 1 : 0;
      if (ones == 5) begin
        line_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int j = 0; j < 8; j++) line_q.push_back(flag[j]);
  endtask

  task automatic push_bit(input logic v, input logic en, input bit last, input int kind);
    exp_t e;
    e.tx = v; e.txen = en; e.last = last; e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int keep, input bit abrt);
    for (int i = 0; i < keep; i++) push_bit(line_q[i], 1'b1, 1'b0, 0);
    if (abrt) begin
      push_bit(1'b0, 1'b1, 1'b0, 0);
      for (int i = 0; i < 7; i++) push_bit(1'b1, 1'b1, 1'b0, 0);
    end
    for (int g = 0; g < GAP; g++) push_bit(1'b1, 1'b0, g == GAP - 1, abrt ? 2 : 1);
  endtask

  task automatic wr(input logic [7:0] b);
    if (buf_q.size() < DEPTH && !model_busy) buf_q.push_back(b);
    host_if.wr_data = b;
    host_if.wr_en   = 1'b1;
    @(negedge clk);
    host_if.wr_en   = 1'b0;
  endtask

  // abort_off < 0: normal frame; otherwise abort that many bits into the 3rd data byte.
  task automatic start_frame(input bit with_wr, input logic [7:0] b, input bit use_kat,
                             input int abort_off);
    int k;
    if (with_wr && buf_q.size() < DEPTH) buf_q.push_back(b);
    frame_len = buf_q.size();
    k = -1;
    if (frame_len > 0) begin
      build_line(use_kat);
      if (abort_off >= 0) k = byte3_pos + abort_off;
      push_frame((k >= 0) ? k : line_q.size(), k >= 0);
      model_busy = 1'b1;
    end
    host_if.start   = 1'b1;
    host_if.wr_data = b;
    host_if.wr_en   = with_wr;
    @(negedge clk);
    host_if.start = 1'b0;
    host_if.wr_en = 1'b0;
    buf_q.delete();
    if (k >= 0) begin
      repeat (k) @(negedge clk);
      host_if.abort = 1'b1;
      @(negedge clk);
      host_if.abort = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout: %0d line bits still pending", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    chk("idle_after_frame", {host_if.busy, 27'd0, host_if.frame_size}, 32'd0);
    model_busy = 1'b0;
  endtask

  // Monitor: a line bit is due after every edge with BitEn=1 while busy.
  logic emit = 1'b0;
  logic rst_edge = 1'b1;
  logic lvl_tx = 1'b1;
  logic lvl_en = 1'b0;
  exp_t mon_e;

  always @(posedge clk) begin
    emit     <= bit_en && host_if.busy && !rst;
    rst_edge <= rst;
  end

  always @(negedge clk) begin
    if (rst_edge) begin
      lvl_tx = 1'b1;
      lvl_en = 1'b0;
      chk("reset_line", {28'd0, tx, tx_en, host_if.done, host_if.aborted}, 32'b1000);
    end else if (emit) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_bit: tx=%b tx_en=%b with no bit expected", tx, tx_en);
      end else begin
        mon_e  = exp_q.pop_front();
        lvl_tx = mon_e.tx;
        lvl_en = mon_e.txen;
        chk("line_bit", {30'd0, tx, tx_en}, {30'd0, mon_e.tx, mon_e.txen});
        if (mon_e.last)
          chk("frame_end", {28'd0, host_if.done, host_if.aborted, host_if.busy,
                            host_if.frame_size == 0},
              {28'd0, mon_e.kind == 1, mon_e.kind == 2, 1'b0, 1'b1});
        else
          chk("no_pulse", {30'd0, host_if.done, host_if.aborted}, 32'd0);
      end
    end else begin
      chk("hold", {28'd0, tx, tx_en, host_if.done, host_if.aborted},
          {28'd0, lvl_tx, lvl_en, 2'b00});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    host_if.wr_data = '0;
    host_if.wr_en   = 1'b0;
    host_if.start   = 1'b0;
    host_if.abort   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {25'd0, tx, tx_en, host_if.busy, host_if.full, host_if.done,
                        host_if.aborted, host_if.frame_size == 0}, 32'b1000001);

    // Known answer "123456789" with the published FCS bytes.
    mode = 0;
    for (int i = 0; i < 9; i++) wr(8'h31 + 8'(i));
    chk("kat_frame_size", 32'(host_if.frame_size), 32'd9);
    start_frame(1'b0, 8'h00, 1'b1, -1);
    chk("busy_after_start", {31'd0, host_if.busy}, 32'd1);
    wait_idle(2000);

    // Single 0xFF: stuffed zero after the fifth 1.
    wr(8'hFF);
    start_frame(1'b0, 8'h00, 1'b0, -1);
    wait_idle(2000);

    // Random frames with random BitEn, biased towards 0xFF to exercise stuffing.
    mode = 1;
    for (int f = 0; f < 5; f++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) wr(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      start_frame(1'b0, 8'h00, 1'b0, -1);
      wait_idle(4000);
    end

    // WrEn and Start together: from empty, and appended to a partial buffer.
    start_frame(1'b1, 8'($urandom), 1'b0, -1);
    wait_idle(2000);
    wr(8'($urandom));
    wr(8'($urandom));
    start_frame(1'b1, 8'($urandom), 1'b0, -1);
    wait_idle(2000);

    // Abort during the 3rd data byte.
    mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) wr(8'($urandom));
    start_frame(1'b0, 8'h00, 1'b0, $urandom_range(0, 7));
    wait_idle(2000);

    // Fill to DEPTH, overflow write and write while busy are dropped.
    mode = 1;
    for (int i = 0; i < DEPTH; i++) wr(8'($urandom));
    chk("fill_full", {26'd0, host_if.full, host_if.frame_size}, {26'd0, 1'b1, 5'(buf_q.size())});
    wr(8'hA5);
    chk("drop_when_full", 32'(host_if.frame_size), 32'(buf_q.size()));
    start_frame(1'b0, 8'h00, 1'b0, -1);
    wr(8'h5A);
    chk("drop_when_busy", {26'd0, host_if.full, host_if.frame_size},
        {26'd0, 1'b1, 5'(frame_len)});
    wait_idle(6000);

    // Start with empty buffer is ignored.
    start_frame(1'b0, 8'h00, 1'b0, -1);
    chk("empty_start", {28'd0, host_if.busy, host_if.frame_size == 0, tx, tx_en}, 32'b0110);
    repeat (5) @(negedge clk);

    // BitEn held low freezes the line after Start.
    mode = 2;
    repeat (2) @(negedge clk);
    wr(8'h7E);
    wr(8'h81);
    start_frame(1'b0, 8'h00, 1'b0, -1);
    repeat (100) @(negedge clk);
    chk("stall_line", {29'd0, tx, tx_en, host_if.busy}, 32'b101);
    mode = 0;
    wait_idle(2000);

    // Reset in the middle of the data field, then a normal frame.
    for (int i = 0; i < 4; i++) wr(8'($urandom));
    start_frame(1'b0, 8'h00, 1'b0, -1);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_busy = 1'b0;
    chk("rst_mid_frame", {29'd0, tx, tx_en, host_if.busy}, 32'b100);
    chk("rst_frame_size", 32'(host_if.frame_size), 32'd0);
    for (int i = 0; i < 6; i++) wr(8'($urandom));
    start_frame(1'b0, 8'h00, 1'b0, -1);
    wait_idle(2000);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
